// File: rtl/merger_pkg.sv
// Shared types and constants for the merger tree: record widths, word types and the coupler FSM states.
package merger_pkg;

    localparam int REC_W = 32;
    localparam int IN_P  = 2;

    typedef logic [REC_W-1:0]   rec_t;
    typedef logic [2*REC_W-1:0] word2_t;
    typedef logic [4*REC_W-1:0] word4_t;

    localparam rec_t TERM_KEY = '0;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } coupler_state_t;

    // A record whose key is TERM_KEY closes a sorted run.
    function automatic logic is_term(input rec_t key);
        return key == TERM_KEY;
    endfunction

endpackage

// File: rtl/coupler_2_to_4_if.sv
// Upstream FIFO pop port and downstream FIFO push port of the 2-to-4 coupler.
interface coupler_2_to_4_if;
    import merger_pkg::*;

    word2_t i_fifo;
    logic   i_fifo_empty;
    logic   o_fifo_read;
    logic   i_fifo_out_ready;
    logic   o_out_fifo_write;
    word4_t o_data;

    modport slave (
        input  i_fifo, i_fifo_empty, i_fifo_out_ready,
        output o_fifo_read, o_out_fifo_write, o_data
    );

    modport master (
        output i_fifo, i_fifo_empty, i_fifo_out_ready,
        input  o_fifo_read, o_out_fifo_write, o_data
    );

endinterface

// File: rtl/coupler_out_reg.sv
// Output holding register: keeps a completed 4-record word until the downstream FIFO accepts it.
module coupler_out_reg
    import merger_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  word4_t data_i,
    input  logic   ready_i,
    output word4_t data_o,
    output logic   valid_o,
    output logic   write_o
);

    word4_t data_q, data_d;
    logic   valid_q, valid_d;

    // A load in the same cycle as a write-out replaces the departing word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign write_o = valid_q & ready_i;

endmodule

// File: rtl/coupler_2_to_4.sv
// Pairs consecutive 2-record words into 4-record words; a lone run terminator is zero-padded.
// Optional macro COUPLER_RUN_CNT_EN adds o_run_count, a count of popped terminator words.
module coupler_2_to_4
    import merger_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    coupler_2_to_4_if.slave  bus
`ifdef COUPLER_RUN_CNT_EN
    ,
    output logic [31:0]      o_run_count
`endif
);

    coupler_state_t state_q, state_d;
    word2_t         lo_q, lo_d;
    word4_t         load_data;
    logic           term;
    logic           out_valid;
    logic           out_free;
    logic           pop;
    logic           load;

    assign term     = is_term(bus.i_fifo[REC_W-1:0]);
    assign out_free = ~out_valid | bus.i_fifo_out_ready;

    // Any pop that completes an output word waits for the holding register to be free.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = {bus.i_fifo, lo_q};
        if (!i_rst && !bus.i_fifo_empty) begin
            case (state_q)
                LOW: begin
                    if (!term) begin
                        pop     = 1'b1;
                        lo_d    = bus.i_fifo;
                        state_d = HIGH;
                    end else if (out_free) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_data = {word2_t'(0), bus.i_fifo};
                    end
                end
                HIGH: begin
                    if (out_free) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = LOW;
                    end
                end
                default: state_d = LOW;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= LOW;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.o_fifo_read = pop;

    coupler_out_reg u_out_reg (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (load),
        .data_i  (load_data),
        .ready_i (bus.i_fifo_out_ready),
        .data_o  (bus.o_data),
        .valid_o (out_valid),
        .write_o (bus.o_out_fifo_write)
    );

`ifdef COUPLER_RUN_CNT_EN
    logic [31:0] run_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_cnt_q <= '0;
        end else if (pop && term) begin
            run_cnt_q <= run_cnt_q + 32'd1;
        end
    end

    assign o_run_count = run_cnt_q;
`else
    // Run counter not built.
`endif

endmodule

// File: tb/tb_coupler_2_to_4.sv
// Randomized bench for coupler_2_to_4 against a queue-based pairing model.
module tb_coupler_2_to_4;
    import merger_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coupler_2_to_4_if bus ();
`ifdef COUPLER_RUN_CNT_EN
    logic [31:0] run_count;
`endif

    coupler_2_to_4 dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef COUPLER_RUN_CNT_EN
        ,
        .o_run_count (run_count)
`endif
    );

    int     checks = 0;
    int     errors = 0;
    word2_t src[$];
    word2_t gen[$];
    word2_t in_log[$];
    word4_t out_log[$];
    bit     half_v, slot_v;
    word2_t half_w;
    word4_t slot_w;
    int     exp_cnt;
    int     dut_pops;
    int     rdy_pct = 100;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        half_v  = 1'b0;
        slot_v  = 1'b0;
        half_w  = '0;
        slot_w  = '0;
        exp_cnt = 0;
        in_log.delete();
        out_log.delete();
    endtask

    // One clock: drive inputs at the falling edge, compare just after, advance the model.
    task automatic step();
        word2_t w;
        bit     ep, ew, t, free;
        @(negedge clk);
        bus.i_fifo_out_ready = ($urandom_range(99) < rdy_pct);
        bus.i_fifo_empty     = (src.size() == 0);
        bus.i_fifo           = (src.size() != 0) ? src[0] : '0;
        #1;
        ew   = slot_v & bus.i_fifo_out_ready;
        free = !slot_v || bus.i_fifo_out_ready;
        ep   = 1'b0;
        t    = 1'b0;
        if (src.size() != 0) begin
            t  = (src[0][REC_W-1:0] == 0);
            ep = (half_v || t) ? free : 1'b1;
        end
        chk("fifo_read", 128'(bus.o_fifo_read), 128'(ep));
        chk("out_write", 128'(bus.o_out_fifo_write), 128'(ew));
        if (slot_v) chk("o_data", bus.o_data, slot_w);
`ifdef COUPLER_RUN_CNT_EN
        chk("run_count", 128'(run_count), 128'(exp_cnt));
`endif
        if (bus.o_fifo_read) dut_pops++;
        if (bus.o_out_fifo_write) out_log.push_back(bus.o_data);
        if (ew) slot_v = 1'b0;
        if (ep) begin
            w = src.pop_front();
            in_log.push_back(w);
            if (t) exp_cnt++;
            if (half_v) begin
                slot_w = {w, half_w};
                slot_v = 1'b1;
                half_v = 1'b0;
            end else if (t) begin
                slot_w = {64'h0, w};
                slot_v = 1'b1;
            end else begin
                half_w = w;
                half_v = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src.size() != 0 || slot_v) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 128'(src.size() != 0 || slot_v), 128'(0));
    endtask

    // Whole-stream view: every popped word, in order, grouped into output words.
    task automatic check_stream(input string tag);
        word4_t exp[$];
        bit     h = 1'b0;
        word2_t hw = '0;
        foreach (in_log[i]) begin
            if (h) begin
                exp.push_back({in_log[i], hw});
                h = 1'b0;
            end else if (in_log[i][REC_W-1:0] == 0) begin
                exp.push_back({64'h0, in_log[i]});
            end else begin
                hw = in_log[i];
                h  = 1'b1;
            end
        end
        chk({tag, "_count"}, 128'(out_log.size()), 128'(exp.size()));
        for (int i = 0; i < out_log.size() && i < exp.size(); i++)
            chk(tag, out_log[i], exp[i]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        bus.i_fifo_empty = (src.size() == 0);
        bus.i_fifo       = (src.size() != 0) ? src[0] : '0;
        rst = 1'b1;
        #1;
        chk("rst_data", bus.o_data, 128'h0);
        chk("rst_write", 128'(bus.o_out_fifo_write), 128'(0));
        chk("rst_read", 128'(bus.o_fifo_read), 128'(0));
`ifdef COUPLER_RUN_CNT_EN
        chk("rst_run_count", 128'(run_count), 128'(0));
`endif
        model_reset();
        bus.i_fifo_empty = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.i_fifo_empty     = 1'b1;
        bus.i_fifo_out_ready = 1'b1;
        bus.i_fifo           = '0;
        model_reset();
        #2;
        chk("init_data", bus.o_data, 128'h0);
        chk("init_read", 128'(bus.o_fifo_read), 128'(0));
        chk("init_write", 128'(bus.o_out_fifo_write), 128'(0));
        #1;
        rst = 1'b0;

        // idle with empty FIFO
        dut_pops = 0;
        repeat (10) begin
            step();
            chk("idle_data", bus.o_data, 128'h0);
        end
        chk("idle_pops", 128'(dut_pops), 128'(0));

        // basic pairing
        src.push_back(64'h00000002_00000001);
        src.push_back(64'h00000004_00000003);
        drain(20);
        chk("pair_n", 128'(out_log.size()), 128'(1));
        if (out_log.size() > 0)
            chk("pair_word", out_log[0], 128'h00000004_00000003_00000002_00000001);
        check_stream("pair_stream");
        in_log.delete();
        out_log.delete();

        // terminator pad
        src.push_back(64'h00000006_00000005);
        src.push_back(64'h00000008_00000007);
        src.push_back(64'h00000000_00000000);
        drain(20);
        chk("pad_n", 128'(out_log.size()), 128'(2));
        if (out_log.size() > 1) begin
            chk("pad_w0", out_log[0], 128'h00000008_00000007_00000006_00000005);
            chk("pad_w1", out_log[1], 128'h0);
        end
        in_log.delete();
        out_log.delete();

        // backpressure
        rdy_pct = 0;
        for (int i = 0; i < 6; i++) src.push_back({32'(i + 100), 32'(i + 10)});
        dut_pops = 0;
        repeat (8) step();
        chk("bp_pops", 128'(dut_pops), 128'(3));
        chk("bp_writes", 128'(out_log.size()), 128'(0));
        rdy_pct = 100;
        drain(40);
        chk("bp_n", 128'(out_log.size()), 128'(3));
        if (out_log.size() > 0)
            chk("bp_w0", out_log[0], 128'h00000065_0000000B_00000064_0000000A);
        check_stream("bp_stream");
        in_log.delete();
        out_log.delete();

        // async reset mid-pair
        src.push_back(64'h0000000A_00000009);
        step();
        src.push_back(64'h0000000C_0000000B);
        src.push_back(64'h0000000E_0000000D);
        reset_pulse();
        drain(20);
        chk("rst_pair_n", 128'(out_log.size()), 128'(1));
        if (out_log.size() > 0)
            chk("rst_pair_word", out_log[0], 128'h0000000E_0000000D_0000000C_0000000B);

`ifdef COUPLER_RUN_CNT_EN
        // three runs ending in terminators
        src.push_back(64'h00000002_00000001);
        src.push_back(64'h00000000_00000000);
        src.push_back(64'h00000005_00000000);
        src.push_back(64'h00000004_00000003);
        src.push_back(64'h00000006_00000005);
        src.push_back(64'h00000007_00000000);
        drain(40);
        chk("runs_lit", 128'(run_count), 128'(3));
        reset_pulse();
        step();
        chk("runs_after_rst", 128'(run_count), 128'(0));
`endif

        // randomized traffic
        in_log.delete();
        out_log.delete();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] key;
            key = ($urandom_range(4) == 0) ? 32'h0 : ($urandom | 32'h1);
            gen.push_back({32'($urandom), key});
        end
        begin
            int cyc = 0;
            while (gen.size() != 0 && cyc < 20000) begin
                if (cyc % 40 == 0) begin
                    case ($urandom_range(3))
                        0: rdy_pct = 0;
                        1: rdy_pct = 30;
                        2: rdy_pct = 70;
                        default: rdy_pct = 100;
                    endcase
                end
                if ($urandom_range(9) < 7) src.push_back(gen.pop_front());
                step();
                cyc++;
            end
            chk("feed_timeout", 128'(gen.size()), 128'(0));
        end
        rdy_pct = 100;
        drain(2000);
        check_stream("rand_stream");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
